// File: rtl/ascii_stream_checker.sv
// ASCII payload checker: validates each character of a frame against a parametrised class
// set, optionally folds whitespace to 0x20, forwards the characters through a FIFO on a
// valid/ready stream and reports frame status until acknowledged.
module ascii_stream_checker #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned MAX_LEN      = 2048,
  parameter bit          ALLOW_DOT    = 1'b0,
  parameter bit          NORMALIZE_WS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  input  logic        ack,
  output logic        done,
  output logic        invalid,
  output logic        too_long,
  output logic [15:0] err_index,
  output logic [7:0]  err_char,
  output logic [15:0] char_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          invalid_q, invalid_d;
  logic          too_long_q, too_long_d;
  logic [15:0]   err_index_q, err_index_d;
  logic [7:0]    err_char_q, err_char_d;
  logic [15:0]   char_count_q, char_count_d;

  logic       is_ws;
  logic       is_valid;
  logic [7:0] fwd_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       accept;
  logic       push;
  logic       pop;
  logic [8:0] head;

  // Character classification and whitespace folding of the incoming beat.
  always_comb begin
    is_ws    = NORMALIZE_WS &&
               (in_data == 8'h09 || in_data == 8'h0A || in_data == 8'h0D);
    is_valid = (in_data >= 8'h30 && in_data <= 8'h39) ||
               (in_data == 8'h20) || (in_data == 8'h2D) ||
               (ALLOW_DOT && in_data == 8'h2E) || is_ws;
    fwd_data = is_ws ? 8'h20 : in_data;
  end

  // Stream handshakes; beats beyond MAX_LEN are dropped except the last, which keeps framing.
  always_comb begin
    fifo_full  = (cnt_q == FullCnt);
    fifo_empty = (cnt_q == '0);
    in_ready   = !rst && (state_q == StIdle || state_q == StRun) && !fifo_full;
    accept     = in_valid && in_ready;
    push       = accept && ((32'(char_count_q) < MAX_LEN) || in_last);
    head       = mem_q[rd_ptr_q];
    out_valid  = !fifo_empty;
    out_data   = out_valid ? head[7:0] : 8'h00;
    out_last   = out_valid && head[8];
    pop        = out_valid && out_ready;
  end

  // FIFO storage and pointer next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_last, fwd_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame FSM and status next-state; status only moves on accepted beats or on ack.
  always_comb begin
    state_d      = state_q;
    invalid_d    = invalid_q;
    too_long_d   = too_long_q;
    err_index_d  = err_index_q;
    err_char_d   = err_char_q;
    char_count_d = char_count_q;
    done         = 1'b0;

    if (accept) begin
      if (char_count_q != 16'hFFFF) begin
        char_count_d = char_count_q + 16'd1;
      end
      if (!push) begin
        too_long_d = 1'b1;
      end
      // Only the first offending character is recorded.
      if (!is_valid && !invalid_q) begin
        invalid_d   = 1'b1;
        err_index_d = char_count_q;
        err_char_d  = in_data;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = in_last ? StDrain : StRun;
        end
      end
      StRun: begin
        if (accept && in_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head[8]) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (ack) begin
          state_d      = StIdle;
          invalid_d    = 1'b0;
          too_long_d   = 1'b0;
          err_index_d  = 16'h0000;
          err_char_d   = 8'h00;
          char_count_d = 16'h0000;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      invalid_q    <= 1'b0;
      too_long_q   <= 1'b0;
      err_index_q  <= 16'h0000;
      err_char_q   <= 8'h00;
      char_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      invalid_q    <= invalid_d;
      too_long_q   <= too_long_d;
      err_index_q  <= err_index_d;
      err_char_q   <= err_char_d;
      char_count_q <= char_count_d;
    end
  end

  // FIFO data array; contents are don't-care while the count is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign invalid    = invalid_q;
  assign too_long   = too_long_q;
  assign err_index  = err_index_q;
  assign err_char   = err_char_q;
  assign char_count = char_count_q;

endmodule

// File: doc/ascii_stream_checker.md
Name: ascii_stream_checker

Overview:
- Streaming successor to the payload character validator.
- Accepts a byte-wide ASCII payload frame from the UART packet path and checks each character against a parametrised class set.
- Optionally normalises whitespace, then forwards the characters through an internal FIFO on a valid/ready stream to the number separator. This replaces the flat character buffer.
- Reports frame status, including the first offending character and its position, and re-arms on an acknowledge instead of needing a reset.

Parameters:
- DEPTH, 64: FIFO entries; power of two, at least 2.
- MAX_LEN, 2048: maximum characters forwarded per frame, 1..65535.
- ALLOW_DOT, 0: when 1, '.' (0x2E) is a valid character.
- NORMALIZE_WS, 1: when 1, TAB (0x09), LF (0x0A) and CR (0x0D) are valid and are forwarded as 0x20.

Ports:
- clk, input, 1: clock; single clock domain.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, 8: payload character.
- in_valid, input, 1: in_data is valid.
- in_last, input, 1: final character of the frame.
- in_ready, output, 1: block accepts a beat this cycle.
- out_data, output, 8: forwarded (possibly normalised) character.
- out_valid, output, 1: out_data is valid.
- out_last, output, 1: final forwarded character of the frame.
- out_ready, input, 1: downstream accepts a beat.
- ack, input, 1: clear status and re-arm; honoured only in DONE.
- done, output, 1: frame fully forwarded and status stable.
- invalid, output, 1: at least one invalid character in the frame.
- too_long, output, 1: frame length exceeded MAX_LEN.
- err_index, output, 16: 0-based index of the first invalid character.
- err_char, output, 8: raw value of the first invalid character.
- char_count, output, 16: accepted beats in the frame; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, FIFO emptied.
  - in_ready=0 during reset.
  - out_valid=0, out_last=0, out_data=0.
  - done=0, invalid=0, too_long=0, err_index=0, err_char=0, char_count=0.
- Reset mid-frame discards all buffered data and status. No partial frame is emitted.
- Valid characters:
  - Always: 0x30–0x39, 0x20, 0x2D.
  - Plus 0x2E if ALLOW_DOT=1.
  - Plus 0x09, 0x0A, 0x0D if NORMALIZE_WS=1.
- Invalid characters are forwarded unchanged. Valid whitespace is forwarded as 0x20 when NORMALIZE_WS=1.
- A beat is accepted when in_valid && in_ready.
- in_ready = (state==IDLE || state==RUN) && !fifo_full. There is no bypass when the FIFO is full, even if it is popped in the same cycle.
- FIFO push/pop:
  - An accepted beat is pushed if char_count < MAX_LEN, or if in_last=1. The last beat is always pushed so framing is preserved.
  - Other beats are dropped and set too_long. Dropped beats are still counted and validated.
  - Entries hold {last, data}. An accepted beat is visible on out_valid the next cycle at the earliest.
  - Pop happens when out_valid && out_ready.
  - Simultaneous push and pop while non-full is legal and keeps the count.
- First invalid beat: at the first accepted invalid beat, err_index <= char_count (pre-increment) and err_char <= in_data, and invalid is set. Later invalid beats do not update err_index or err_char.
- char_count increments per accepted beat and holds at 0xFFFF.
- FSM:
  - IDLE: on an accepted beat, go to RUN, or to DRAIN if in_last=1.
  - RUN: on an accepted beat with in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. When the entry with last=1 is popped, go to DONE.
  - DONE: done=1, in_ready=0. Status outputs are held. On ack=1, clear status and char_count and go to IDLE. done deasserts the next cycle.
  - ack outside DONE is ignored.
- Status outputs are valid once done=1. They may be observed earlier but are not final until then.
- out_valid/out_data/out_last must not change while out_valid=1 && out_ready=0.

Test Plan:
- Frame "12 -3" (5 beats, last on '3'), out_ready=1 -> out stream 31 32 20 2D 33 with out_last on 0x33; done=1; invalid=0; char_count=5; ack -> done=0 next cycle, char_count=0.
- Frame "4a5b", ALLOW_DOT=0 -> all 4 chars forwarded unchanged; invalid=1, err_index=1, err_char=0x61; the 'b' at index 3 does not overwrite them.
- NORMALIZE_WS=1, frame 0x31 0x0D 0x0A 0x32 -> out 31 20 20 32; invalid=0. With NORMALIZE_WS=0 -> invalid=1, err_index=1, err_char=0x0D.
- DEPTH=4, out_ready=0 for 10 cycles on a 6-char frame -> in_ready drops after 4 accepts. Then release out_ready -> all 6 chars delivered in order, none lost or duplicated.
- MAX_LEN=3, frame "12345" -> out 31 32 33 35 with out_last on 0x35; too_long=1; char_count=5.
- rst asserted mid-frame after 2 beats -> all outputs at reset values next cycle, FIFO empty. A new frame "7" then completes with char_count=1 and out_last on 0x37.
